// File: rtl/inst_data_mem_arbiter_if.sv
// Request/ack bundle between the IF/MEM stage requesters, the arbiter and the RAM port.
// Latency: none, wires only.
// Backpressure: requests are held until the matching one-cycle ack.
interface inst_data_mem_arbiter_if;
  // Fetch requester
  logic        IReq;
  logic [31:0] IAddress;
  logic        IAck;
  logic [31:0] IDataOut;
  logic        IErr;
  // Load/store requester
  logic        DReq;
  logic        DReadWrite;
  logic [1:0]  DSize;
  logic [31:0] DAddress;
  logic [31:0] DDataIn;
  logic        DAck;
  logic [31:0] DDataOut;
  logic        DErr;
  // RAM port
  logic        MemEnable;
  logic        MemReadWrite;
  logic [1:0]  MemSize;
  logic [31:0] MemAddress;
  logic [31:0] MemDataIn;
  logic [31:0] MemDataOut;

  // Arbiter side
  modport slave (
    input  IReq, IAddress,
    output IAck, IDataOut, IErr,
    input  DReq, DReadWrite, DSize, DAddress, DDataIn,
    output DAck, DDataOut, DErr,
    output MemEnable, MemReadWrite, MemSize, MemAddress, MemDataIn,
    input  MemDataOut
  );

  // Requester / RAM side
  modport master (
    output IReq, IAddress,
    input  IAck, IDataOut, IErr,
    output DReq, DReadWrite, DSize, DAddress, DDataIn,
    input  DAck, DDataOut, DErr,
    input  MemEnable, MemReadWrite, MemSize, MemAddress, MemDataIn,
    output MemDataOut
  );
endinterface

// File: rtl/inst_data_mem_arbiter.sv
// Shares one 256x8 RAM port between fetch (I) and load/store (D); D has priority, starvation counter protects I.
// Latency: valid access acks in the third cycle counting the sampling IDLE cycle; rejected access in the second.
// Backpressure: requesters hold Req until Ack; the non-owner is simply not sampled until the next IDLE.
module inst_data_mem_arbiter #(
  parameter int DEPTH    = 256,
  parameter int MAX_WAIT = 3
) (
  input logic                      Clk,
  input logic                      nReset,
  inst_data_mem_arbiter_if.slave   bus
);

  localparam int                 WCW      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0]     WAIT_MAX = WCW'(MAX_WAIT);
  localparam logic [32:0]        LAST_ADR = 33'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          r_state;
  logic [WCW-1:0]  r_wait_cnt;
  logic            r_owner_d;

  logic            r_mem_en;
  logic            r_mem_rw;
  logic [1:0]      r_mem_size;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_mem_wdat;

  logic            r_iack;
  logic            r_ierr;
  logic [31:0]     r_idata;
  logic            r_dack;
  logic            r_derr;
  logic [31:0]     r_ddata;

  logic            w_any_req;
  logic            w_grant_d;
  logic            w_sel_rw;
  logic [1:0]      w_sel_size;
  logic [31:0]     w_sel_addr;
  logic [31:0]     w_sel_wdat;
  logic [32:0]     w_bytes;
  logic [32:0]     w_last_byte;
  logic            w_reject;
  logic [31:0]     w_rdata_masked;

  // Arbitration: D wins unless I has already lost MAX_WAIT times in a row
  always_comb begin
    w_any_req  = bus.IReq | bus.DReq;
    w_grant_d  = bus.DReq & ~(bus.IReq & (r_wait_cnt == WAIT_MAX));
    w_sel_rw   = w_grant_d ? bus.DReadWrite : 1'b1;
    w_sel_size = w_grant_d ? bus.DSize      : 2'b10;
    w_sel_addr = w_grant_d ? bus.DAddress   : bus.IAddress;
    w_sel_wdat = w_grant_d ? bus.DDataIn    : 32'd0;
  end

  // Size/alignment/range checks; range is done in 33 bits so addresses near 2^32 cannot wrap into range
  always_comb begin
    case (w_sel_size)
      2'b00:   w_bytes = 33'd1;
      2'b01:   w_bytes = 33'd2;
      default: w_bytes = 33'd4;
    endcase
    w_last_byte = {1'b0, w_sel_addr} + w_bytes - 33'd1;
    w_reject    = (w_sel_size == 2'b11)
                | ((w_sel_size == 2'b01) & w_sel_addr[0])
                | ((w_sel_size == 2'b10) & (w_sel_addr[1:0] != 2'b00))
                | (w_last_byte > LAST_ADR);
  end

  // Trim RAM read data to the access size so stray upper bits never reach a requester
  always_comb begin
    case (r_mem_size)
      2'b00:   w_rdata_masked = {24'd0, bus.MemDataOut[7:0]};
      2'b01:   w_rdata_masked = {16'd0, bus.MemDataOut[15:0]};
      default: w_rdata_masked = bus.MemDataOut;
    endcase
  end

  // Main FSM: every output is a register updated here
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_owner_d  <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_rw   <= 1'b0;
      r_mem_size <= 2'b00;
      r_mem_addr <= 32'd0;
      r_mem_wdat <= 32'd0;
      r_iack     <= 1'b0;
      r_ierr     <= 1'b0;
      r_idata    <= 32'd0;
      r_dack     <= 1'b0;
      r_derr     <= 1'b0;
      r_ddata    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner_d <= w_grant_d;
            if (!w_grant_d) begin
              r_wait_cnt <= '0;
            end else if (bus.IReq && (r_wait_cnt != WAIT_MAX)) begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_reject) begin
              // Rejected: RAM untouched, ack with error straight away
              r_state <= RESP;
              if (w_grant_d) begin
                r_dack  <= 1'b1;
                r_derr  <= 1'b1;
                r_ddata <= 32'd0;
              end else begin
                r_iack  <= 1'b1;
                r_ierr  <= 1'b1;
                r_idata <= 32'd0;
              end
            end else begin
              r_state    <= ACCESS;
              r_mem_en   <= 1'b1;
              r_mem_rw   <= w_sel_rw;
              r_mem_size <= w_sel_size;
              r_mem_addr <= w_sel_addr;
              r_mem_wdat <= w_sel_wdat;
            end
          end
        end
        ACCESS: begin
          // RAM read is combinational, so data is valid at the closing edge
          r_mem_en <= 1'b0;
          r_state  <= RESP;
          if (r_owner_d) begin
            r_dack  <= 1'b1;
            r_derr  <= 1'b0;
            r_ddata <= r_mem_rw ? w_rdata_masked : 32'd0;
          end else begin
            r_iack  <= 1'b1;
            r_ierr  <= 1'b0;
            r_idata <= w_rdata_masked;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_iack  <= 1'b0;
          r_ierr  <= 1'b0;
          r_idata <= 32'd0;
          r_dack  <= 1'b0;
          r_derr  <= 1'b0;
          r_ddata <= 32'd0;
        end
        default: begin
          r_state  <= IDLE;
          r_mem_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IAck         = r_iack;
  assign bus.IErr         = r_ierr;
  assign bus.IDataOut     = r_idata;
  assign bus.DAck         = r_dack;
  assign bus.DErr         = r_derr;
  assign bus.DDataOut     = r_ddata;
  assign bus.MemEnable    = r_mem_en;
  assign bus.MemReadWrite = r_mem_rw;
  assign bus.MemSize      = r_mem_size;
  assign bus.MemAddress   = r_mem_addr;
  assign bus.MemDataIn    = r_mem_wdat;

endmodule

// File: tb/tb_inst_data_mem_arbiter.sv
// Bench for inst_data_mem_arbiter: directed requests, behavioural big-endian RAM, scoreboard monitor.
// Latency: checked per request (ack two edges after the sampling edge for valid, one for rejected).
// Backpressure: requests held until ack and dropped in the ack cycle.
module tb_inst_data_mem_arbiter;

  logic Clk    = 1'b0;
  logic nReset = 1'b0;
  always #5 Clk = ~Clk;

  inst_data_mem_arbiter_if bus ();

  inst_data_mem_arbiter #(.DEPTH(256), .MAX_WAIT(3)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  // Behavioural RAM: big-endian, right-justified data, combinational read
  logic [7:0] mem [0:255];
  logic [7:0] ra;
  always_comb begin
    ra = bus.MemAddress[7:0];
    bus.MemDataOut = 32'd0;
    if (bus.MemEnable) begin
      case (bus.MemSize)
        2'b00:   bus.MemDataOut = {24'd0, mem[ra]};
        2'b01:   bus.MemDataOut = {16'd0, mem[ra], mem[8'(ra + 8'd1)]};
        default: bus.MemDataOut = {mem[ra], mem[8'(ra + 8'd1)], mem[8'(ra + 8'd2)], mem[8'(ra + 8'd3)]};
      endcase
    end
  end
  always @(posedge Clk) begin
    if (bus.MemEnable && !bus.MemReadWrite) begin
      case (bus.MemSize)
        2'b00: mem[ra] <= bus.MemDataIn[7:0];
        2'b01: begin
          mem[ra]              <= bus.MemDataIn[15:8];
          mem[8'(ra + 8'd1)]   <= bus.MemDataIn[7:0];
        end
        default: begin
          mem[ra]              <= bus.MemDataIn[31:24];
          mem[8'(ra + 8'd1)]   <= bus.MemDataIn[23:16];
          mem[8'(ra + 8'd2)]   <= bus.MemDataIn[15:8];
          mem[8'(ra + 8'd3)]   <= bus.MemDataIn[7:0];
        end
      endcase
    end
  end

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    bit          err;
    int          men;
  } exp_t;

  exp_t sbq[$];
  int   n_vec    = 0;
  int   n_bad    = 0;
  int   men_cnt  = 0;
  int   ack_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit is_d, input logic [31:0] data, input bit err);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.err  = err;
    e.men  = err ? 0 : 1;
    return e;
  endfunction

  // Monitor: pops one expectation per ack, also checks how many cycles the RAM was enabled
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!nReset) begin
        men_cnt = 0;
      end else begin
        if (bus.MemEnable) men_cnt++;
        if (bus.IAck || bus.DAck) begin
          ack_seen++;
          if (sbq.size() == 0) begin
            chk("unexpected_ack", 64'({bus.IAck, bus.DAck}), 64'd0);
          end else begin
            e = sbq.pop_front();
            chk("ack_owner", 64'({bus.IAck, bus.DAck}), e.is_d ? 64'd1 : 64'd2);
            chk("ack_data", 64'(e.is_d ? bus.DDataOut : bus.IDataOut), 64'(e.data));
            chk("ack_err", 64'(e.is_d ? bus.DErr : bus.IErr), 64'(e.err));
            chk("mem_en_cycles", 64'(men_cnt), 64'(e.men));
          end
          men_cnt = 0;
        end
      end
    end
  end

  // One request from idle to ack; drops Req in the ack cycle
  task automatic issue(input bit is_d, input bit rw, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdat,
                       input logic [31:0] exp_data, input bit exp_err);
    int lat;
    bit got;
    sbq.push_back(mk(is_d, exp_data, exp_err));
    @(negedge Clk);
    if (is_d) begin
      bus.DReadWrite = rw;
      bus.DSize      = size;
      bus.DAddress   = addr;
      bus.DDataIn    = wdat;
      bus.DReq       = 1'b1;
    end else begin
      bus.IAddress   = addr;
      bus.IReq       = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (lat < 20 && !got) begin
      @(negedge Clk);
      lat++;
      got = is_d ? bus.DAck : bus.IAck;
    end
    chk(is_d ? "d_latency" : "i_latency", 64'(lat), exp_err ? 64'd1 : 64'd2);
    bus.DReq = 1'b0;
    bus.IReq = 1'b0;
  endtask

  initial begin
    int lat;
    int acks;
    int gap;
    int a0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hE3; mem[1] = 8'hA0; mem[2] = 8'h10; mem[3] = 8'h05;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;

    // Reset held with both requests high: everything stays at zero
    bus.IReq = 1'b1; bus.IAddress = 32'd0;
    bus.DReq = 1'b1; bus.DReadWrite = 1'b1; bus.DSize = 2'b10;
    bus.DAddress = 32'd0; bus.DDataIn = 32'd0;
    nReset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      chk("rst_ctrl", 64'({bus.IAck, bus.IErr, bus.DAck, bus.DErr,
                          bus.MemEnable, bus.MemReadWrite, bus.MemSize}), 64'd0);
      chk("rst_data", {bus.IDataOut, bus.DDataOut}, 64'd0);
      chk("rst_mem", {bus.MemAddress, bus.MemDataIn}, 64'd0);
    end

    // Release with only the fetch pending: first fetch of word 0
    bus.DReq = 1'b0;
    sbq.push_back(mk(1'b0, 32'hE3A01005, 1'b0));
    nReset = 1'b1;
    lat = 0;
    while (lat < 20 && !bus.IAck) begin
      @(negedge Clk);
      lat++;
    end
    chk("post_rst_i_latency", 64'(lat), 64'd2);
    bus.IReq = 1'b0;

    // Plain fetch, write then reads of various sizes, boundary bytes
    issue(1'b0, 1'b1, 2'b10, 32'd4,   32'd0,        32'h11223344, 1'b0);
    issue(1'b1, 1'b0, 2'b10, 32'd8,   32'hDEADBEEF, 32'h00000000, 1'b0);
    issue(1'b1, 1'b1, 2'b00, 32'd9,   32'd0,        32'h000000AD, 1'b0);
    issue(1'b1, 1'b1, 2'b01, 32'd10,  32'd0,        32'h0000BEEF, 1'b0);
    issue(1'b1, 1'b1, 2'b10, 32'd8,   32'd0,        32'hDEADBEEF, 1'b0);
    issue(1'b1, 1'b0, 2'b00, 32'd255, 32'hFFFFFF55, 32'h00000000, 1'b0);
    issue(1'b1, 1'b1, 2'b00, 32'd255, 32'd0,        32'h00000055, 1'b0);
    issue(1'b1, 1'b1, 2'b01, 32'd254, 32'd0,        32'h00000055, 1'b0);

    // Rejected accesses: misaligned, illegal size, past the end, wrap-around
    issue(1'b1, 1'b1, 2'b10, 32'h102,      32'd0, 32'd0, 1'b1);
    issue(1'b1, 1'b1, 2'b01, 32'd3,        32'd0, 32'd0, 1'b1);
    issue(1'b1, 1'b1, 2'b11, 32'd0,        32'd0, 32'd0, 1'b1);
    issue(1'b1, 1'b1, 2'b10, 32'd254,      32'd0, 32'd0, 1'b1);
    issue(1'b1, 1'b1, 2'b10, 32'h100,      32'd0, 32'd0, 1'b1);
    issue(1'b1, 1'b0, 2'b00, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1);
    issue(1'b0, 1'b1, 2'b10, 32'h102,      32'd0, 32'd0, 1'b1);
    issue(1'b0, 1'b1, 2'b10, 32'd2,        32'd0, 32'd0, 1'b1);

    // Contention, both held: D,D,D,I,D,D,D,I
    for (int k = 0; k < 2; k++) begin
      sbq.push_back(mk(1'b1, 32'hE3A01005, 1'b0));
      sbq.push_back(mk(1'b1, 32'hE3A01005, 1'b0));
      sbq.push_back(mk(1'b1, 32'hE3A01005, 1'b0));
      sbq.push_back(mk(1'b0, 32'h11223344, 1'b0));
    end
    @(negedge Clk);
    bus.IAddress = 32'd4; bus.IReq = 1'b1;
    bus.DReadWrite = 1'b1; bus.DSize = 2'b10; bus.DAddress = 32'd0; bus.DReq = 1'b1;
    acks = 0;
    for (int c = 0; c < 60 && acks < 8; c++) begin
      @(negedge Clk);
      if (bus.IAck || bus.DAck) acks++;
    end
    bus.IReq = 1'b0; bus.DReq = 1'b0;
    chk("contention_acks", 64'(acks), 64'd8);

    // Simultaneous, D drops after its ack: I served in the very next IDLE
    sbq.push_back(mk(1'b1, 32'hE3A01005, 1'b0));
    sbq.push_back(mk(1'b0, 32'h11223344, 1'b0));
    @(negedge Clk);
    bus.IReq = 1'b1; bus.DReq = 1'b1;
    for (int c = 0; c < 20 && !bus.DAck; c++) @(negedge Clk);
    bus.DReq = 1'b0;
    gap = 0;
    while (gap < 20 && !bus.IAck) begin
      @(negedge Clk);
      gap++;
    end
    bus.IReq = 1'b0;
    chk("i_after_d_gap", 64'(gap), 64'd3);

    // Reset in the middle of a D write while I also waits
    @(negedge Clk);
    bus.IReq = 1'b1; bus.IAddress = 32'd4;
    bus.DReq = 1'b1; bus.DReadWrite = 1'b0; bus.DSize = 2'b10;
    bus.DAddress = 32'd16; bus.DDataIn = 32'h12345678;
    @(negedge Clk);
    chk("abort_in_access", 64'(bus.MemEnable), 64'd1);
    chk("abort_wait_pre", 64'(dut.r_wait_cnt), 64'd1);
    a0 = ack_seen;
    nReset = 1'b0; bus.IReq = 1'b0; bus.DReq = 1'b0;
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    repeat (4) @(negedge Clk);
    chk("abort_no_ack", 64'(ack_seen - a0), 64'd0);
    chk("abort_state_idle", 64'(dut.r_state), 64'd0);
    chk("abort_wait_clr", 64'(dut.r_wait_cnt), 64'd0);
    chk("abort_mem_en", 64'(bus.MemEnable), 64'd0);

    // Fetch still works after the aborted access
    issue(1'b0, 1'b1, 2'b10, 32'd0, 32'd0, 32'hE3A01005, 1'b0);
    repeat (3) @(negedge Clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Watchdog so a stuck design cannot hang the run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
